signal_edge_analyzer: RTL and testbench
=======================================

// Module: signal_edge_analyzer
// PURPOSE
//   Acquisition-side counterpart of the signal generator: consumes 14-bit sample stream, detects
//   rising/falling threshold crossings with hysteresis, measures period, high time, min and max
//   per period. Feeds trigger/measurement readout of the scope; bench loops generator output back.
// PARAMETERS
//   CNT_W   16   width of period/high-time counters (sample units)
// PORTS
//   Clock          in   1      system clock, 50 MHz
//   Reset          in   1      synchronous, active-high
//   SampleValid    in   1      SampleIn valid this cycle; counters advance only on valid samples
//   SampleIn       in   14     unsigned sample
//   ThresholdHigh  in   14     rising crossing level (sample >= ThresholdHigh)
//   ThresholdLow   in   14     falling crossing level (sample <= ThresholdLow)
//   MeasValid      out  1      one-cycle pulse: Period/HighTime/SampleMax/SampleMin updated
//   Period         out  CNT_W  samples between consecutive rising crossings
//   HighTime       out  CNT_W  samples from rising crossing to following falling crossing
//   SampleMax      out  14     max sample in window [rise, next rise)
//   SampleMin      out  14     min sample in same window
//   Timeout        out  1      one-cycle pulse: no crossing within 2^CNT_W-1 samples
//   ConfigErr      out  1      level: ThresholdLow > ThresholdHigh
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation discards partial window.
//   All outputs registered; every output change occurs on the clock edge that accepts the sample
//   causing it (visible one cycle after the valid sample is presented).
//   ConfigErr = registered (ThresholdLow > ThresholdHigh); while set, state forced to IDLE,
//     no MeasValid/Timeout. Thresholds otherwise sampled live each valid sample.
//   States (transitions only on SampleValid=1):
//     IDLE  : sample <= ThresholdLow -> ARMED. Otherwise stay (never measure from unknown phase).
//     ARMED : sample >= ThresholdHigh -> HIGH; rise sample = r0: Cnt<=0, Max<=Min<=sample.
//     HIGH  : Cnt+=1, update Max/Min; sample <= ThresholdLow -> LOW, HighTime register
//             latched internally = Cnt+1 (incremented value).
//     LOW   : Cnt+=1, update Max/Min; sample >= ThresholdHigh -> rising crossing r1:
//             Period<=Cnt+1, HighTime<=latched, SampleMax/Min<=window values (excluding r1),
//             MeasValid<=1; window restarts at r1 (Cnt<=0, Max<=Min<=sample), stay HIGH.
//   Hysteresis: samples strictly between thresholds never change state.
//   Timeout: in HIGH or LOW, if Cnt+1 == 2^CNT_W-1 without the awaited crossing -> Timeout<=1,
//     state IDLE, no MeasValid. Crossing on that same sample wins over timeout.
//   SampleValid=0: no state/counter change; MeasValid, Timeout deassert (pulses last one cycle).
//   Period, HighTime, SampleMax, SampleMin hold last values between MeasValid pulses.
//   Counter arithmetic unsigned, CNT_W bits, never wraps (timeout fires first).
// TESTING
//   SampleValid=1, SampleIn alternating 0x0000/0x0FFF, Thr H=0x800 L=0x400 -> after first full
//     period MeasValid every 2 cycles, Period=2, HighTime=1, Max=0x0FFF, Min=0x0000.
//   Same stream, SampleValid high every other cycle -> Period=2, HighTime=1 (samples, not clocks).
//   Square wave 0x100/0xF00 high 3 low 5 samples with 0x600 glitch in high phase, H=0x800 L=0x400
//     -> no extra crossing; Period=8, HighTime=3, Min=0x100, Max=0xF00.
//   CNT_W=4, SampleIn constant 0x0FFF after arming -> Timeout pulse on 15th sample after rise,
//     state IDLE, MeasValid never set; resumes after sample <= L then >= H.
//   Reset pulsed in LOW state -> next cycle all outputs 0; first MeasValid only after full period.
//   ThresholdLow=0x900 > ThresholdHigh=0x800 -> ConfigErr=1, no MeasValid; restore -> ConfigErr=0.

Source files
------------

// File: rtl/signal_edge_analyzer.sv
// Hysteresis crossing detector and per-period measurement unit for a 14-bit sample stream.
// Latency: outputs change on the edge that accepts the causing sample. No backpressure; a low SampleValid stalls the block.
module signal_edge_analyzer #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             SampleValid,
  input  logic [13:0]      SampleIn,
  input  logic [13:0]      ThresholdHigh,
  input  logic [13:0]      ThresholdLow,
  output logic             MeasValid,
  output logic [CNT_W-1:0] Period,
  output logic [CNT_W-1:0] HighTime,
  output logic [13:0]      SampleMax,
  output logic [13:0]      SampleMin,
  output logic             Timeout,
  output logic             ConfigErr
);

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_lat;
  logic [13:0]      win_max;
  logic [13:0]      win_min;
  logic [13:0]      nxt_max;
  logic [13:0]      nxt_min;
  logic             cfg_bad;
  logic             at_rise;
  logic             at_fall;
  logic             at_limit;

  assign cfg_bad  = (ThresholdLow > ThresholdHigh);
  assign at_rise  = (SampleIn >= ThresholdHigh);
  assign at_fall  = (SampleIn <= ThresholdLow);
  assign cnt_inc  = cnt + CNT_W'(1);
  assign at_limit = (cnt_inc == CNT_LAST);
  assign nxt_max  = (SampleIn > win_max) ? SampleIn : win_max;
  assign nxt_min  = (SampleIn < win_min) ? SampleIn : win_min;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      high_lat  <= '0;
      win_max   <= '0;
      win_min   <= '0;
      MeasValid <= 1'b0;
      Period    <= '0;
      HighTime  <= '0;
      SampleMax <= '0;
      SampleMin <= '0;
      Timeout   <= 1'b0;
      ConfigErr <= 1'b0;
    end else begin
      MeasValid <= 1'b0;
      Timeout   <= 1'b0;
      ConfigErr <= cfg_bad;
      if (cfg_bad) begin
        state <= IDLE;
      end else if (SampleValid) begin
        unique case (state)
          // Only arm from a known-low level so the first window starts on a true rise.
          IDLE: if (at_fall) state <= ARMED;
          ARMED: begin
            if (at_rise) begin
              state   <= HIGH;
              cnt     <= '0;
              win_max <= SampleIn;
              win_min <= SampleIn;
            end
          end
          HIGH: begin
            cnt     <= cnt_inc;
            win_max <= nxt_max;
            win_min <= nxt_min;
            if (at_fall) begin
              state    <= LOW;
              high_lat <= cnt_inc;
            end else if (at_limit) begin
              state   <= IDLE;
              Timeout <= 1'b1;
            end
          end
          LOW: begin
            if (at_rise) begin
              // The new rise closes the old window (excluding itself) and opens the next one.
              Period    <= cnt_inc;
              HighTime  <= high_lat;
              SampleMax <= win_max;
              SampleMin <= win_min;
              MeasValid <= 1'b1;
              cnt       <= '0;
              win_max   <= SampleIn;
              win_min   <= SampleIn;
              state     <= HIGH;
            end else begin
              cnt     <= cnt_inc;
              win_max <= nxt_max;
              win_min <= nxt_min;
              if (at_limit) begin
                state   <= IDLE;
                Timeout <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_signal_edge_analyzer.sv
// Bench for signal_edge_analyzer: directed waveforms plus random stream against a window/queue model.
module tb_signal_edge_analyzer;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             Clock;
  logic             Reset;
  logic             SampleValid;
  logic [13:0]      SampleIn;
  logic [13:0]      ThresholdHigh;
  logic [13:0]      ThresholdLow;
  logic             MeasValid;
  logic [CNT_W-1:0] Period;
  logic [CNT_W-1:0] HighTime;
  logic [13:0]      SampleMax;
  logic [13:0]      SampleMin;
  logic             Timeout;
  logic             ConfigErr;

  signal_edge_analyzer #(.CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .SampleValid(SampleValid), .SampleIn(SampleIn),
    .ThresholdHigh(ThresholdHigh), .ThresholdLow(ThresholdLow),
    .MeasValid(MeasValid), .Period(Period), .HighTime(HighTime),
    .SampleMax(SampleMax), .SampleMin(SampleMin), .Timeout(Timeout), .ConfigErr(ConfigErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  int mv_cnt  = 0;
  int to_cnt  = 0;

  // Model: phase 0 waiting for low, 1 waiting for rise, 2 after rise, 3 after fall.
  int          phase = 0;
  int          hl_len = 0;
  int          win[$];
  logic [CNT_W-1:0] exp_period = '0, exp_high = '0;
  logic [13:0] exp_max = '0, exp_min = '0;
  logic        exp_mv = 1'b0, exp_to = 1'b0, exp_cfg = 1'b0;

  task automatic model_step(input logic rst, input logic vld, input int s, input int th, input int tl);
    int mx, mn;
    exp_mv = 1'b0;
    exp_to = 1'b0;
    if (rst) begin
      phase = 0; win.delete(); exp_period = '0; exp_high = '0;
      exp_max = '0; exp_min = '0; exp_cfg = 1'b0;
      return;
    end
    exp_cfg = (tl > th);
    if (tl > th) begin
      phase = 0; win.delete();
      return;
    end
    if (!vld) return;
    case (phase)
      0: if (s <= tl) phase = 1;
      1: if (s >= th) begin phase = 2; win.delete(); win.push_back(s); end
      2: begin
        if (s <= tl) begin hl_len = win.size(); win.push_back(s); phase = 3; end
        else if (win.size() == MAXC) begin exp_to = 1'b1; phase = 0; end
        else win.push_back(s);
      end
      default: begin
        if (s >= th) begin
          mx = win[0]; mn = win[0];
          foreach (win[i]) begin
            if (win[i] > mx) mx = win[i];
            if (win[i] < mn) mn = win[i];
          end
          exp_period = CNT_W'(win.size());
          exp_high   = CNT_W'(hl_len);
          exp_max    = 14'(mx);
          exp_min    = 14'(mn);
          exp_mv     = 1'b1;
          win.delete(); win.push_back(s); phase = 2;
        end else if (win.size() == MAXC) begin exp_to = 1'b1; phase = 0; end
        else win.push_back(s);
      end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Clock) begin
    chk("MeasValid", MeasValid, exp_mv);
    chk("Timeout", Timeout, exp_to);
    chk("ConfigErr", ConfigErr, exp_cfg);
    chk("Period", Period, exp_period);
    chk("HighTime", HighTime, exp_high);
    chk("SampleMax", SampleMax, exp_max);
    chk("SampleMin", SampleMin, exp_min);
  end

  task automatic cycle(input logic rst, input logic vld, input int s);
    Reset = rst; SampleValid = vld; SampleIn = 14'(s);
    @(posedge Clock);
    model_step(rst, vld, s, ThresholdHigh, ThresholdLow);
    @(negedge Clock);
    if (MeasValid) mv_cnt++;
    if (Timeout) to_cnt++;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    mv_cnt = 0; to_cnt = 0;
  endtask

  initial begin
    Reset = 1'b1; SampleValid = 1'b0; SampleIn = '0;
    ThresholdHigh = 14'h800; ThresholdLow = 14'h400;
    @(negedge Clock);
    do_reset();
    chk("reset_period", Period, 0);
    chk("reset_mv", MeasValid, 0);

    // Alternating full-rate stream.
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, (i % 2) ? 'h0FFF : 'h0000);
    chk("alt_period", Period, 2);
    chk("alt_high", HighTime, 1);
    chk("alt_max", SampleMax, 'h0FFF);
    chk("alt_min", SampleMin, 'h0000);
    chk("alt_mv_count", mv_cnt, 9);

    // Same stream with a valid sample every other clock.
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b0, (i % 2) == 0, ((i / 2) % 2) ? 'h0FFF : 'h0000);
    chk("half_period", Period, 2);
    chk("half_high", HighTime, 1);
    chk("half_mv_count", mv_cnt, 9);

    // Square wave, 3 high (glitched) + 5 low samples.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      cycle(1'b0, 1'b1, 'h0F00); cycle(1'b0, 1'b1, 'h0600); cycle(1'b0, 1'b1, 'h0F00);
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 'h0100);
    end
    cycle(1'b0, 1'b1, 'h0F00);
    chk("sq_period", Period, 8);
    chk("sq_high", HighTime, 3);
    chk("sq_max", SampleMax, 'h0F00);
    chk("sq_min", SampleMin, 'h0100);
    chk("sq_mv_count", mv_cnt, 3);

    // Stuck high after arming: single timeout on the 15th sample after the rise.
    do_reset();
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b1, 'h0FFF);
    for (int k = 1; k <= 14; k++) cycle(1'b0, 1'b1, 'h0FFF);
    chk("to_not_yet", to_cnt, 0);
    cycle(1'b0, 1'b1, 'h0FFF);
    chk("to_pulse", Timeout, 1);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 'h0FFF);
    chk("to_count", to_cnt, 1);
    chk("to_no_mv", mv_cnt, 0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, (i % 2) ? 'h0FFF : 'h0000);
    chk("to_resume_mv", mv_cnt, 2);

    // Reset while in the low half of a period.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, (i % 2) ? 'h0FFF : 'h0000);
    cycle(1'b1, 1'b0, 0);
    chk("rst_low_period", Period, 0);
    chk("rst_low_max", SampleMax, 0);
    mv_cnt = 0;
    cycle(1'b0, 1'b1, 'h0FFF);
    cycle(1'b0, 1'b1, 'h0000);
    cycle(1'b0, 1'b1, 'h0FFF);
    cycle(1'b0, 1'b1, 'h0000);
    chk("rst_low_no_early_mv", mv_cnt, 0);
    cycle(1'b0, 1'b1, 'h0FFF);
    chk("rst_low_first_mv", mv_cnt, 1);

    // Inverted thresholds.
    ThresholdLow = 14'h900; ThresholdHigh = 14'h800; mv_cnt = 0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, (i % 2) ? 'h0FFF : 'h0000);
    chk("cfg_err_set", ConfigErr, 1);
    chk("cfg_no_mv", mv_cnt, 0);
    ThresholdLow = 14'h400;
    cycle(1'b0, 1'b1, 0);
    chk("cfg_err_clear", ConfigErr, 0);

    // Randomized stream.
    ThresholdHigh = 14'h2000; ThresholdLow = 14'h1000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        ThresholdHigh = 14'($urandom_range(0, 'h3FFF));
        ThresholdLow  = 14'($urandom_range(0, 'h3FFF));
      end else if ($urandom_range(0, 99) == 0) begin
        ThresholdHigh = 14'h2000; ThresholdLow = 14'h1000;
      end
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 'h3FFF));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
